sys_array_ctrl: RTL and testbench

//  Job sequencer for the weight-stationary systolic array.
//  - On start: latches a weight set and drives a one-cycle param_load.
//  - Streams input vectors through a valid/ready port, skewing element j by j cycles onto array_in.
//  - Captures and de-skews the per-row outputs, then queues each full result vector in an output FIFO.
//  - Credit-based input throttling prevents FIFO overflow, because the array itself cannot stall.

---
 rtl/sys_array_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sys_array_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_ctrl
// Brief    : Job sequencer for a weight-stationary systolic array: weight load,
//            input skew, result de-skew and a credit-throttled result FIFO.
//            Optional perf counters when SYS_ARRAY_CTRL_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
module sys_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int RES_LAT    = ARRAY_L,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [DATA_WIDTH*ARRAY_W*ARRAY_L-1:0] weight_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH*ARRAY_L-1:0]         in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [2*DATA_WIDTH*ARRAY_W-1:0]       out_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  param_load,
  output logic [DATA_WIDTH*ARRAY_W*ARRAY_L-1:0] param_data,
  output logic [DATA_WIDTH*ARRAY_L-1:0]         array_in,
  input  logic [2*DATA_WIDTH*ARRAY_W-1:0]       array_out
`ifdef SYS_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]                           perf_busy_cyc,
  output logic [31:0]                           perf_stall_cyc
`endif
);

  localparam int c_rw      = 2 * DATA_WIDTH;
  localparam int c_tag_len = RES_LAT + ARRAY_W;
  localparam int c_cw      = $clog2(OUT_DEPTH + 1);
  localparam int c_pw      = $clog2(OUT_DEPTH);
  localparam logic [c_cw:0] c_depth = (c_cw + 1)'(OUT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                                state_q, state_d;
  logic                                  done_q, done_d;
  logic [DATA_WIDTH*ARRAY_W*ARRAY_L-1:0] param_q, param_d;
  logic [c_tag_len-1:0]                  tag_q, tag_d, last_q, last_d;
  logic [c_cw-1:0]                       inflight_q, inflight_d, count_q, count_d;
  logic [c_pw-1:0]                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_rw*ARRAY_W-1:0]               mem_q [OUT_DEPTH];
  logic [c_rw*ARRAY_W-1:0]               w_aligned;

  logic w_accept, w_push, w_pop;

  assign in_ready   = (state_q == S_STREAM) &&
                      (({1'b0, count_q} + {1'b0, inflight_q}) < c_depth);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = tag_q[c_tag_len-1];
  assign out_valid  = (count_q != '0);
  assign w_pop      = out_valid && out_ready;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy       = (state_q != S_IDLE);
  assign param_load = (state_q == S_LOAD);
  assign param_data = param_q;
  assign done       = done_q;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    param_d    = param_q;
    tag_d      = {tag_q[c_tag_len-2:0], w_accept};
    last_d     = {last_q[c_tag_len-2:0], w_accept && in_last};
    inflight_d = inflight_q + c_cw'(w_accept) - c_cw'(w_push);
    count_d    = count_q + c_cw'(w_push) - c_cw'(w_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (w_push) wr_ptr_d = (wr_ptr_q == c_pw'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + c_pw'(1);
    if (w_pop)  rd_ptr_d = (rd_ptr_q == c_pw'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + c_pw'(1);
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        param_d = weight_data;
      end
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (w_accept && in_last) state_d = S_DRAIN;
      // The last-tagged vector is the final one in flight, so its push empties the pipe.
      S_DRAIN: if (w_push && last_q[c_tag_len-1]) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      param_q    <= '0;
      tag_q      <= '0;
      last_q     <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      param_q    <= param_d;
      tag_q      <= tag_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (w_push) mem_q[wr_ptr_q] <= w_aligned;
    end
  end

  // Lane j sits behind j+1 registers; idle cycles inject zeros.
  for (genvar j = 0; j < ARRAY_L; j++) begin : g_skew
    logic [DATA_WIDTH-1:0] sk_q [0:j];
    logic [DATA_WIDTH-1:0] sk_d [0:j];
    always_comb begin
      sk_d[0] = w_accept ? in_data[DATA_WIDTH*j +: DATA_WIDTH] : '0;
      for (int k = 1; k <= j; k++) sk_d[k] = sk_q[k-1];
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= j; k++) sk_q[k] <= '0;
      end else begin
        sk_q <= sk_d;
      end
    end
    assign array_in[DATA_WIDTH*j +: DATA_WIDTH] = sk_q[j];
  end

  // Row t needs ARRAY_W-1-t registers so all rows reach the FIFO write together.
  for (genvar t = 0; t < ARRAY_W; t++) begin : g_deskew
    localparam int c_n = ARRAY_W - 1 - t;
    if (c_n == 0) begin : g_direct
      assign w_aligned[c_rw*t +: c_rw] = array_out[c_rw*t +: c_rw];
    end else begin : g_delay
      logic [c_rw-1:0] ds_q [0:c_n-1];
      logic [c_rw-1:0] ds_d [0:c_n-1];
      always_comb begin
        ds_d[0] = array_out[c_rw*t +: c_rw];
        for (int k = 1; k < c_n; k++) ds_d[k] = ds_q[k-1];
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < c_n; k++) ds_q[k] <= '0;
        end else begin
          ds_q <= ds_d;
        end
      end
      assign w_aligned[c_rw*t +: c_rw] = ds_q[c_n-1];
    end
  end

`ifdef SYS_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (busy && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
    if ((state_q == S_STREAM) && in_valid && !in_ready && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_array_ctrl
// Brief    : Scoreboard bench for sys_array_ctrl with a behavioural array model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sys_array_ctrl;

  localparam int RES_LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] weight_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;
  logic         done;
  logic         param_load;
  logic [127:0] param_data;
  logic [31:0]  array_in;
  logic [63:0]  array_out;
`ifdef SYS_ARRAY_CTRL_PERF_EN
  logic [31:0]  perf_busy_cyc;
  logic [31:0]  perf_stall_cyc;
`endif

  sys_array_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .weight_data (weight_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .param_load  (param_load),
    .param_data  (param_data),
    .array_in    (array_in),
    .array_out   (array_out)
`ifdef SYS_ARRAY_CTRL_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  logic [127:0] wts = '0;
  logic [63:0]  sb [$];
  int           pop_times [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [127:0] w, input logic [31:0] x);
    logic [63:0] r;
    logic [15:0] s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = '0;
      for (int j = 0; j < 4; j++) s += 16'(w[8*(4*i+j) +: 8]) * 16'(x[8*j +: 8]);
      r[16*i +: 16] = s;
    end
    return r;
  endfunction

  // Array model: row t at cycle c sums lane j as it was RES_LAT+t-j cycles earlier.
  initial begin
    logic [127:0] arr_w;
    logic [31:0]  hist [0:15];
    logic [63:0]  nxt;
    logic [15:0]  s;
    arr_w = '0;
    for (int k = 0; k < 16; k++) hist[k] = '0;
    array_out = '0;
    forever begin
      @(negedge clk);
      if (param_load) arr_w = param_data;
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = array_in;
      for (int t = 0; t < 4; t++) begin
        s = '0;
        for (int j = 0; j < 4; j++)
          s += 16'(arr_w[8*(4*t+j) +: 8]) * 16'(hist[RES_LAT+t-j][8*j +: 8]);
        nxt[16*t +: 16] = s;
      end
      array_out = nxt;
    end
  end

  // Monitor: push expectations on acceptance, pop and compare on output handshake.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        sb.push_back(model(wts, in_data));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) check("out_data", out_data, sb.pop_front());
        pop_times.push_back(cyc);
        pop_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_job(input logic [127:0] w);
    wts = w;
    weight_data = w;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("param_load", param_load, 1);
    check("param_data", param_data, w);
    check("busy_load", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic drop_after);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_to", in_ready, 1);
    @(posedge clk); #1;
    if (drop_after) begin
      in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    logic [127:0] w_id;
    logic         seen_ov;
    logic         seen_done;
    reset = 1'b1; start = 1'b0; weight_data = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_flags", {in_ready, out_valid, busy, done, param_load}, 0);
    check("rst_param", param_data, 0);
    check("rst_array_in", array_in, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;

    // Identity weights, single vector, exact latency.
    w_id = '0;
    for (int i = 0; i < 4; i++) w_id[8*(5*i) +: 8] = 8'd1;
    done_cnt = 0;
    start_job(w_id);
    send({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b1);
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      check("ov_latency", out_valid, (n == 8));
      if (n == 8) begin
        check("id_out", out_data, {16'd4, 16'd3, 16'd2, 16'd1});
        check("done_latency", done, 1);
      end
    end
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("busy_idle", busy, 0);
    @(posedge clk); #1;

    // All-2 weights, start ignored mid-STREAM, three back-to-back vectors.
    start_job({16{8'd2}});
    start = 1'b1;
    weight_data = {16{8'hAA}};
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("ign_load", param_load, 0);
      check("ign_data", param_data, {16{8'd2}});
    end
    @(posedge clk); #1;
    pop_times.delete();
    send({4{8'd1}}, 1'b0, 1'b0);
    send({4{8'd5}}, 1'b0, 1'b0);
    send({4{8'd255}}, 1'b1, 1'b1);
    wait_done(100);
    repeat (4) @(negedge clk);
    check("b2b_count", pop_times.size(), 3);
    if (pop_times.size() >= 3) begin
      check("b2b_gap0", pop_times[1] - pop_times[0], 1);
      check("b2b_gap1", pop_times[2] - pop_times[1], 1);
    end
    check("model_8_40_2040", model({16{8'd2}}, {4{8'd255}}), {4{16'd2040}});
    @(posedge clk); #1;

    // Same job with in_valid toggling.
    pop_cnt = 0;
    start_job({16{8'd2}});
    send({4{8'd1}}, 1'b0, 1'b1);
    @(posedge clk); #1;
    send({4{8'd5}}, 1'b0, 1'b1);
    @(posedge clk); #1;
    send({4{8'd255}}, 1'b1, 1'b1);
    wait_done(100);
    repeat (4) @(negedge clk);
    check("toggle_count", pop_cnt, 3);
    @(posedge clk); #1;

    // Credit throttling with the FIFO blocked.
    out_ready = 1'b0;
    pop_cnt = 0;
    start_job({16{8'd1}});
    acc_cnt = 0;
    fork
      begin
        for (int v = 1; v <= 12; v++) send({4{8'(v)}}, (v == 12), (v == 12));
      end
      begin
        repeat (40) @(negedge clk);
        check("thr_accepted", acc_cnt, 8);
        check("thr_in_ready", in_ready, 0);
        check("thr_out_valid", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done(200);
    repeat (12) @(negedge clk);
    check("thr_pops", pop_cnt, 12);
    @(posedge clk); #1;

    // Reset in the middle of STREAM aborts the job.
    done_cnt = 0;
    start_job({16{8'd1}});
    send({4{8'd3}}, 1'b0, 1'b1);
    send({4{8'd7}}, 1'b0, 1'b1);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_flags", {in_ready, out_valid, busy, done, param_load}, 0);
    check("mid_rst_param", param_data, 0);
    check("mid_rst_array_in", array_in, 0);
    check("mid_rst_out_data", out_data, 0);
    seen_ov = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      seen_ov |= out_valid;
      seen_done |= done;
    end
    check("mid_rst_no_out", seen_ov, 0);
    check("mid_rst_no_done", seen_done, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
